mc_main_fsm: RTL and testbench

MC_MAIN_FSM -- requirements
Module: mc_main_fsm

---
 rtl/mc_main_fsm.sv | 118 +++++++++++
 tb/tb_mc_main_fsm.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mc_main_fsm.sv
// Multi-cycle processor main control FSM: sequences fetch/decode/execute/writeback.
// Optional branch-with-link state enabled by defining MC_BRANCH_LINK_EN.
module mc_main_fsm (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       LinkReg,
  output logic       Undef,
  output logic [3:0] StateOut
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXECR  = 4'd6,  EXECI  = 4'd7,
    ALUWB  = 4'd8,  BRANCH = 4'd9,  BL     = 4'd10, UNDEF  = 4'd11
  } state_t;

  state_t state, nextState;
  logic   irw, npc, regw, memw, br, lnk, und;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= FETCH;
    else       state <= nextState;
  end

  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:  nextState = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b00: nextState = Funct[5] ? EXECI : EXECR;
          2'b01: nextState = MEMADR;
`ifdef MC_BRANCH_LINK_EN
          2'b10: nextState = Funct[4] ? BL : BRANCH;
`else
          2'b10: nextState = BRANCH;
`endif
          default: nextState = UNDEF;
        endcase
      end
      MEMADR: nextState = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  nextState = MemReady ? MEMWB : MEMRD;
      MEMWR:  nextState = MemReady ? FETCH : MEMWR;
      EXECR,
      EXECI:  nextState = ALUWB;
`ifdef MC_BRANCH_LINK_EN
      BL:     nextState = BRANCH;
`endif
      default: nextState = FETCH;
    endcase
  end

  always_comb begin
    irw       = 1'b0;
    npc       = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 1'b0;
    ResultSrc = 2'b00;
    regw      = 1'b0;
    memw      = 1'b0;
    br        = 1'b0;
    lnk       = 1'b0;
    und       = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        irw = MemReady; npc = MemReady;
      end
      DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB:  begin ResultSrc = 2'b01; regw = 1'b1; end
      MEMWR:  begin AdrSrc = 1'b1; memw = 1'b1; end
      EXECR:  ALUOp = 1'b1;
      EXECI:  begin ALUSrcB = 2'b01; ALUOp = 1'b1; end
      ALUWB:  regw = 1'b1;
      BRANCH: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; br = 1'b1;
      end
`ifdef MC_BRANCH_LINK_EN
      BL: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        regw = 1'b1; lnk = 1'b1;
      end
`endif
      UNDEF:  und = 1'b1;
      default: ;
    endcase
  end

  // Strobes are forced low while reset is held, independent of MemReady.
  assign IRWrite  = irw  & ~RESET;
  assign NextPC   = npc  & ~RESET;
  assign RegW     = regw & ~RESET;
  assign MemW     = memw & ~RESET;
  assign Branch   = br   & ~RESET;
  assign LinkReg  = lnk  & ~RESET;
  assign Undef    = und  & ~RESET;
  assign StateOut = state;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Self-checking bench for mc_main_fsm: per-instruction expected state traces
// built from instruction class and wait-state counts, plus async reset checks.
module tb_mc_main_fsm;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite, NextPC, AdrSrc, ALUOp, RegW, MemW, Branch, LinkReg, Undef;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] StateOut;
  logic [14:0] outs;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [3:0] st; logic mr; } cyc_t;

  mc_main_fsm dut (
    .CLK(CLK), .RESET(RESET), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .LinkReg(LinkReg), .Undef(Undef),
    .StateOut(StateOut)
  );

  always #5 CLK = ~CLK;

  assign outs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
                 RegW, MemW, Branch, LinkReg, Undef};

  // Expected control word for a given state, straight from the output table.
  function automatic logic [14:0] expOut(input logic [3:0] st, input logic mr, input logic rst);
    logic irw, npc, adr, aop, rw, mw, br, lr, ud;
    logic [1:0] sa, sb, rs;
    {irw, npc, adr, aop, rw, mw, br, lr, ud} = '0;
    sa = 2'b00; sb = 2'b00; rs = 2'b00;
    case (st)
      4'd0:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; irw = mr & ~rst; npc = mr & ~rst; end
      4'd1:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      4'd2:  sb = 2'b01;
      4'd3:  adr = 1'b1;
      4'd4:  begin rs = 2'b01; rw = 1'b1; end
      4'd5:  begin adr = 1'b1; mw = 1'b1; end
      4'd6:  aop = 1'b1;
      4'd7:  begin sb = 2'b01; aop = 1'b1; end
      4'd8:  rw = 1'b1;
      4'd9:  begin sa = 2'b10; sb = 2'b01; rs = 2'b10; br = 1'b1; end
      4'd10: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; rw = 1'b1; lr = 1'b1; end
      4'd11: ud = 1'b1;
      default: ;
    endcase
    return {irw, npc, adr, sa, sb, aop, rs, rw, mw, br, lr, ud};
  endfunction

  task automatic check(input string tag, input logic [3:0] expSt, input logic [14:0] expOv);
    vectors++;
    assert ({StateOut, outs} === {expSt, expOv}) else begin
      miscompares++;
      $error("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
             tag, StateOut, outs, expSt, expOv);
    end
  endtask

  // Called just after a falling edge; leaves time at the next falling edge.
  task automatic step(input string tag, input logic [3:0] st, input logic mr);
    MemReady = mr;
    #1;
    check(tag, st, expOut(st, mr, 1'b0));
    @(negedge CLK);
  endtask

  // Expected state trace for one instruction, built from its class and wait counts.
  function automatic void buildTrace(input logic [1:0] op, input logic [5:0] fn,
                                     input int fw, input int mw, ref cyc_t q[$]);
    q = {};
    repeat (fw) q.push_back('{4'd0, 1'b0});
    q.push_back('{4'd0, 1'b1});
    q.push_back('{4'd1, 1'($urandom)});
    case (op)
      2'b00: begin
        q.push_back('{fn[5] ? 4'd7 : 4'd6, 1'($urandom)});
        q.push_back('{4'd8, 1'($urandom)});
      end
      2'b01: begin
        q.push_back('{4'd2, 1'($urandom)});
        if (fn[0]) begin
          repeat (mw) q.push_back('{4'd3, 1'b0});
          q.push_back('{4'd3, 1'b1});
          q.push_back('{4'd4, 1'($urandom)});
        end else begin
          repeat (mw) q.push_back('{4'd5, 1'b0});
          q.push_back('{4'd5, 1'b1});
        end
      end
      2'b10: begin
`ifdef MC_BRANCH_LINK_EN
        if (fn[4]) q.push_back('{4'd10, 1'($urandom)});
`endif
        q.push_back('{4'd9, 1'($urandom)});
      end
      default: q.push_back('{4'd11, 1'($urandom)});
    endcase
  endfunction

  task automatic runInstr(input string tag, input logic [1:0] op, input logic [5:0] fn,
                          input int fw, input int mw);
    cyc_t q[$];
    Op = op; Funct = fn;
    buildTrace(op, fn, fw, mw, q);
    foreach (q[i]) step(tag, q[i].st, q[i].mr);
  endtask

  initial begin
    RESET = 1'b1; MemReady = 1'b1; Op = 2'b00; Funct = 6'd0;
    @(negedge CLK);
    #1 check("reset_hold", 4'd0, expOut(4'd0, 1'b1, 1'b1));
    @(negedge CLK);
    RESET = 1'b0;

    // Directed instruction classes, zero and nonzero wait states.
    runInstr("dp_reg",   2'b00, 6'b000000, 0, 0);
    runInstr("dp_imm",   2'b00, 6'b100000, 0, 0);
    runInstr("load_w2",  2'b01, 6'b000001, 0, 2);
    runInstr("store_f3", 2'b01, 6'b000000, 3, 1);
    runInstr("br_link",  2'b10, 6'b010000, 0, 0);
    runInstr("br_plain", 2'b10, 6'b000000, 1, 0);
    runInstr("undef",    2'b11, 6'b111111, 0, 0);

    // Async reset while MemW is asserted in MEMWR.
    Op = 2'b01; Funct = 6'b000000;
    step("rst_wr_pre", 4'd0, 1'b1);
    step("rst_wr_pre", 4'd1, 1'b0);
    step("rst_wr_pre", 4'd2, 1'b0);
    step("rst_wr_pre", 4'd5, 1'b0);
    MemReady = 1'b0;
    #1 check("rst_wr_memw", 4'd5, expOut(4'd5, 1'b0, 1'b0));
    RESET = 1'b1; MemReady = 1'b1;
    #1 check("rst_wr_async", 4'd0, expOut(4'd0, 1'b1, 1'b1));
    @(negedge CLK);
    RESET = 1'b0;
    runInstr("after_rst", 2'b00, 6'b100000, 0, 0);

    // Async reset in the middle of a MEMRD wait.
    Op = 2'b01; Funct = 6'b000001;
    step("rst_rd_pre", 4'd0, 1'b1);
    step("rst_rd_pre", 4'd1, 1'b1);
    step("rst_rd_pre", 4'd2, 1'b1);
    step("rst_rd_pre", 4'd3, 1'b0);
    MemReady = 1'b0;
    #1 RESET = 1'b1;
    #1 check("rst_rd_async", 4'd0, expOut(4'd0, 1'b0, 1'b1));
    @(negedge CLK);
    RESET = 1'b0;
    runInstr("after_rst2", 2'b11, 6'b000000, 1, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      runInstr("random", 2'($urandom), 6'($urandom),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
